// File: rtl/game_clock_sequencer.sv
// Scoreboard game clock: BCD period countdown, period counter, run/pause/expiry FSM and horn.
// Optional tenths-of-a-second display under last minute: define GAME_CLOCK_TENTHS_EN.
module game_clock_sequencer #(
  parameter int CLK_HZ      = 100000000,
  parameter int PERIOD_MIN  = 12,
  parameter int NUM_PERIODS = 4,
  parameter int BUZZ_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clock_reset,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] period,
  output logic       running,
  output logic       scoring_enable,
  output logic       buzzer,
  output logic       game_over
);

`ifdef GAME_CLOCK_TENTHS_EN
  localparam int TICK_CYC = (CLK_HZ / 10 < 1) ? 1 : CLK_HZ / 10;
`else
  localparam int TICK_CYC = CLK_HZ;
`endif
  localparam int DIV_W = $clog2(TICK_CYC + 1);
  localparam int BZ_W  = $clog2(BUZZ_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSED, S_PEND, S_OVER} state_e;
  // te is the tenths digit; it stays 0 unless the tenths build is selected.
  typedef struct packed {
    logic [3:0] mt, mo, st, so, te;
  } time_t;

  localparam time_t FULL_T = '{4'(PERIOD_MIN / 10), 4'(PERIOD_MIN % 10), 4'd0, 4'd0, 4'd0};

  function automatic time_t dec(input time_t t);
    time_t r;
    logic  b;
    r = t;
`ifdef GAME_CLOCK_TENTHS_EN
    b    = (r.te == 4'd0);
    r.te = b ? 4'd9 : r.te - 4'd1;
`else
    b = 1'b1;
`endif
    if (b) begin b = (r.so == 4'd0); r.so = b ? 4'd9 : r.so - 4'd1; end
    if (b) begin b = (r.st == 4'd0); r.st = b ? 4'd5 : r.st - 4'd1; end
    if (b) begin b = (r.mo == 4'd0); r.mo = b ? 4'd9 : r.mo - 4'd1; end
    if (b) r.mt = r.mt - 4'd1;
    return r;
  endfunction

  function automatic logic [15:0] disp(input time_t t);
    logic [15:0] d;
    d = {t.mt, t.mo, t.st, t.so};
`ifdef GAME_CLOCK_TENTHS_EN
    if (t.mt == 4'd0 && t.mo == 4'd0) d = {t.st, t.so, t.te, 4'hF};
`endif
    return d;
  endfunction

  state_e           state_q, state_d;
  time_t            tm_q, tm_d, tm_dec;
  logic [2:0]       period_q, period_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BZ_W-1:0]  bz_cnt_q, bz_cnt_d;
  logic             start_q, start_edge, tick;
  logic             buzzer_q, running_q, scen_q, over_q;
  logic [15:0]      disp_q;

  assign start_edge = start & ~start_q;
  assign tick       = (state_q == S_RUN) && !pause && (div_q == DIV_W'(TICK_CYC - 1));
  assign tm_dec     = (tm_q == '0) ? tm_q : dec(tm_q);

  always_comb begin
    state_d  = state_q;
    tm_d     = tm_q;
    period_d = period_q;
    div_d    = div_q;
    bz_cnt_d = (bz_cnt_q != '0) ? bz_cnt_q - BZ_W'(1) : '0;
    case (state_q)
      S_IDLE: if (start_edge && !pause) begin
        state_d = S_RUN;
        div_d   = '0;
      end
      S_RUN: begin
        // Pause takes precedence over a coincident tick; divider phase is kept.
        if (pause) state_d = S_PAUSED;
        else if (tick) begin
          div_d = '0;
          tm_d  = tm_dec;
          if (tm_dec == '0) begin
            bz_cnt_d = BZ_W'(BUZZ_CYCLES);
            if (period_q < 3'(NUM_PERIODS)) begin
              state_d = S_PEND;
              tm_d    = FULL_T;
            end else begin
              state_d = S_OVER;
            end
          end
        end else div_d = div_q + DIV_W'(1);
      end
      S_PAUSED: if (!pause) state_d = S_RUN;
      S_PEND: if (start_edge && !pause) begin
        state_d  = S_RUN;
        period_d = period_q + 3'd1;
        div_d    = '0;
      end
      S_OVER:  tm_d = '0;
      default: state_d = S_IDLE;
    endcase
    if (clock_reset) begin
      state_d  = S_IDLE;
      tm_d     = FULL_T;
      period_d = 3'd1;
      div_d    = '0;
      bz_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tm_q      <= FULL_T;
      period_q  <= 3'd1;
      div_q     <= '0;
      bz_cnt_q  <= '0;
      start_q   <= 1'b0;
      buzzer_q  <= 1'b0;
      running_q <= 1'b0;
      scen_q    <= 1'b0;
      over_q    <= 1'b0;
      disp_q    <= disp(FULL_T);
    end else begin
      state_q   <= state_d;
      tm_q      <= tm_d;
      period_q  <= period_d;
      div_q     <= div_d;
      bz_cnt_q  <= bz_cnt_d;
      start_q   <= start;
      buzzer_q  <= (bz_cnt_d != '0);
      running_q <= (state_d == S_RUN);
      scen_q    <= (state_d == S_RUN) || (state_d == S_PAUSED);
      over_q    <= (state_d == S_OVER);
      disp_q    <= disp(tm_d);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = disp_q;
  assign period         = period_q;
  assign running        = running_q;
  assign scoring_enable = scen_q;
  assign buzzer         = buzzer_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_game_clock_sequencer.sv
// Directed bench for game_clock_sequencer: vector table for a full two-period game, plus
// hand sequences for async reset mid-run and clock_reset colliding with pause and tick.
module tb_game_clock_sequencer;
  logic       clock = 1'b0, reset = 1'b0, start = 1'b0, pause = 1'b0, clock_reset = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] period;
  logic       running, scoring_enable, buzzer, game_over;
  int         checks = 0, errors = 0;

  game_clock_sequencer #(.CLK_HZ(10), .PERIOD_MIN(1), .NUM_PERIODS(2), .BUZZ_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .clock_reset(clock_reset),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .period(period), .running(running), .scoring_enable(scoring_enable),
    .buzzer(buzzer), .game_over(game_over));

  always #5 clock = ~clock;

  typedef struct {
    logic        s, p, cr;
    int          n;
    logic [15:0] dig;
    int          per;
    logic        run, sce, bz, go;
  } vec_t;

  vec_t tbl[24];

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] dig, input int per,
                         input logic r, input logic sc, input logic bz, input logic g);
    chk({tag, ".digits"}, int'({min_tens, min_ones, sec_tens, sec_ones}), int'(dig));
    chk({tag, ".period"}, int'(period), per);
    chk({tag, ".running"}, int'(running), int'(r));
    chk({tag, ".scoring_enable"}, int'(scoring_enable), int'(sc));
    chk({tag, ".buzzer"}, int'(buzzer), int'(bz));
    chk({tag, ".game_over"}, int'(game_over), int'(g));
  endtask

  initial begin
    //          s     p     cr    n    digits    per run   sce   bz    go
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1,   16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1,   16'h0100, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 9,   16'h0100, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1,   16'h0059, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3,   16'h0059, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1,   16'h0059, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 49,  16'h0059, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1,   16'h0059, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 6,   16'h0059, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1,   16'h0058, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 579, 16'h0001, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1,   16'h0100, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2,   16'h0100, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1,   16'h0100, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1,   16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1,   16'h0100, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 599, 16'h0001, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1,   16'h0000, 2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1,   16'h0000, 2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 5,   16'h0000, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1,   16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 3,   16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    // start with pause held in IDLE must be ignored
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1,   16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 2,   16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0};

    step(3);
    chk_all("in_reset", 16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    chk_all("after_reset", 16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      start = tbl[i].s; pause = tbl[i].p; clock_reset = tbl[i].cr;
      step(tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].dig, tbl[i].per, tbl[i].run, tbl[i].sce,
              tbl[i].bz, tbl[i].go);
    end

    // Async reset mid-RUN, between divider counts.
    start = 1'b1; step(1); start = 1'b0;
    step(15);
    chk_all("pre_async", 16'h0059, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_all("async_reset", 16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock); reset = 1'b1;
    step(1);
    chk_all("post_async", 16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // clock_reset with pause on the tick cycle: IDLE, full time, no decrement.
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    chk_all("pre_collide", 16'h0100, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    clock_reset = 1'b1; pause = 1'b1;
    step(1);
    chk_all("collide", 16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_reset = 1'b0; pause = 1'b0;
    step(12);
    chk_all("collide_idle", 16'h0100, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_clock_sequencer.md
Name: game_clock_sequencer

Overview:
- Controls the scoreboard game timer.
- Runs a per-period countdown in BCD, counts periods, and moves the game through idle, run, pause, period-end and game-over.
- Drives the timer digits to the seven-segment display controller.
- Gates point entry through scoring_enable so scores change only during live play.

Parameters:
- CLK_HZ, 100000000, clock cycles per 1 s tick (testbenches use small values).
- PERIOD_MIN, 12, period length in whole minutes, 1..99.
- NUM_PERIODS, 4, number of regulation periods, 1..7.
- BUZZ_CYCLES, 50000000, buzzer pulse length in cycles.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start/resume request; level input, rising edge detected internally; synchronous and debounced upstream.
- pause  in  1  level; high holds the clock.
- clock_reset  in  1  synchronous restart to period 1, full time, IDLE.
- min_tens  out  4  BCD minutes tens.
- min_ones  out  4  BCD minutes ones.
- sec_tens  out  4  BCD seconds tens.
- sec_ones  out  4  BCD seconds ones.
- period  out  3  current period, 1..NUM_PERIODS.
- running  out  1  high only in RUN.
- scoring_enable  out  1  high in RUN and PAUSED.
- buzzer  out  1  end-of-period horn.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset values (reset low): state IDLE; time = PERIOD_MIN:00 in BCD; period = 1; divider = 0; start_q = 0; buzzer = 0; running = 0; scoring_enable = 0; game_over = 0.
- start_edge = start & ~start_q. start_q is a register updated every cycle.
- All outputs are registered. running rises on the clock edge that first samples start_edge.
- Divider: counts 0..CLK_HZ-1 only in RUN. tick = (divider == CLK_HZ-1 in RUN), then divider wraps to 0.
- Divider holds its value in PAUSED, so the sub-second phase is preserved.
- Divider clears on entry to RUN from IDLE or PERIOD_END.
- Countdown on tick: decrement sec_ones with a BCD borrow chain.
  - sec_ones 0 -> 9 and borrow from sec_tens.
  - sec_tens 0 -> 5 and borrow from min_ones.
  - min_ones 0 -> 9 and borrow from min_tens.
  - Time never goes below 00:00.
- States:
  - IDLE: time full, wait. start_edge with pause low -> RUN. start_edge with pause high is ignored.
  - RUN: pause high -> PAUSED. pause wins over a coincident tick: no decrement that cycle. Tick that makes time 00:00 -> PERIOD_END if period < NUM_PERIODS, else GAME_OVER.
  - PAUSED: pause low -> RUN. Divider resumes from its held count.
  - PERIOD_END: time reloaded to PERIOD_MIN:00 on entry. start_edge (pause low) -> period+1, RUN.
  - GAME_OVER: time held 00:00; start and pause ignored; exits only via clock_reset or reset.
- buzzer: asserted for exactly BUZZ_CYCLES cycles, starting the cycle after the expiry tick. It continues into the next state even if start arrives early.
- clock_reset: highest synchronous priority. Next cycle: IDLE, period 1, full time, divider 0, buzzer 0.
- Async reset mid-operation returns every register to its reset value immediately.

Optional Feature:
- Macro: GAME_CLOCK_TENTHS_EN.
- Enabled:
  - Divider tick is CLK_HZ/10 cycles; an internal BCD tenths digit decrements first.
  - While min_tens and min_ones are both 0, the display remaps: min_tens = sec_tens, min_ones = sec_ones, sec_tens = tenths, sec_ones = 4'hF (blank code).
  - Expiry is at 00:00.0; the first tick from 12:00.0 gives 11:59.9.
- Disabled: 1 s tick, no tenths digit, mm:ss always.

Test Plan:
- Settings for all cases: CLK_HZ=10, PERIOD_MIN=1, NUM_PERIODS=2, BUZZ_CYCLES=4.
- reset low 3 cycles then high -> digits 0,1,0,0; period=1; running=0; scoring_enable=0; game_over=0.
- start high 1 cycle -> running=1 next cycle. 10 cycles later digits = 0,0,5,9; scoring_enable=1.
- In RUN after 3 divider counts, pause high 50 cycles -> digits frozen, running=0, scoring_enable=1. Release -> next decrement exactly 7 cycles after RUN re-entry.
- Run to 00:00 in period 1 -> buzzer high exactly 4 cycles; PERIOD_END; digits 0,1,0,0; scoring_enable=0. start -> period=2, running=1.
- Expire period 2 -> game_over=1, digits 0,0,0,0, start ignored. clock_reset 1 cycle -> IDLE, period=1, digits 0,1,0,0, game_over=0.
- Assert reset low mid-RUN between divider counts -> all outputs at reset values without waiting for a clock edge. Check clock_reset and pause coincident with tick -> clock_reset wins.
